// File: rtl/fp_unpacker.sv
// fp_unpacker: IEEE single/double operand -> unpacked {s, e, f, lz, flags} for the FPU datapath.
// Latency: 1 edge for zero/normal/inf/nan; floor(lz/SHIFT_STEP)+1 edges for denormals.
// Backpressure: result holds in DONE until out_ready; in_ready only in IDLE or while a DONE result is taken.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; db selects double (1) or single (0, uses fp_in[63:32])
//   out_valid/out_ready result handshake
//   s, e, f, lz, flags  sign, 13-bit two's-complement exponent, 53-bit significand (f[52] leading),
//                       denormal shift count, {ZERO, NAN, INF, SNAN, DENORM}
// Build option: define FP_UNPACK_FTZ_EN to flush denormals to zero at accept.
module fp_unpacker #(
  parameter int SHIFT_STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        db,
  input  logic [63:0] fp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        s,
  output logic [12:0] e,
  output logic [52:0] f,
  output logic [5:0]  lz,
  output logic [4:0]  flags
);

  localparam int FLAG_ZERO   = 4;
  localparam int FLAG_NAN    = 3;
  localparam int FLAG_INF    = 2;
  localparam int FLAG_SNAN   = 1;
  localparam int FLAG_DENORM = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        s_q, s_d;
  logic [12:0] e_q, e_d;
  logic [52:0] f_q, f_d;
  logic [5:0]  lz_q, lz_d;
  logic [4:0]  flags_q, flags_d;
  logic        accept;

  // ---------------------------------------------------------------------------
  // Field extraction. Single fractions are left-aligned into the 52-bit field so
  // the quiet bit is frac[51] for both formats.
  // ---------------------------------------------------------------------------
  logic [10:0] exp_fld;
  logic [10:0] exp_max;
  logic [51:0] frac;
  logic [12:0] bias;
  logic        exp_is_zero, exp_is_max, frac_is_zero;

  always_comb begin
    if (db) begin
      exp_fld = fp_in[62:52];
      frac    = fp_in[51:0];
      exp_max = 11'h7FF;
      bias    = 13'd1023;
    end else begin
      exp_fld = {3'b000, fp_in[62:55]};
      frac    = {fp_in[54:32], 29'b0};
      exp_max = 11'h0FF;
      bias    = 13'd127;
    end
  end

  assign exp_is_zero  = (exp_fld == 11'd0);
  assign exp_is_max   = (exp_fld == exp_max);
  assign frac_is_zero = (frac == 52'd0);

  // ---------------------------------------------------------------------------
  // One normalization step. The accept edge already performs the first step on
  // the raw denormal, which is what makes the latency floor(lz/SHIFT_STEP)+1.
  // Later steps work on the registered working value while in NORM.
  // ---------------------------------------------------------------------------
  logic [52:0] step_f_src, step_f;
  logic [12:0] step_e_src, step_e;
  logic [5:0]  step_lz_src, step_lz;
  logic [5:0]  step_k, step_sh;
  logic        step_win_zero;

  always_comb begin
    if (state_q == NORM) begin
      step_f_src  = f_q;
      step_e_src  = e_q;
      step_lz_src = lz_q;
    end else begin
      step_f_src  = {1'b0, frac};
      step_e_src  = 13'd1 - bias;
      step_lz_src = 6'd0;
    end

    // Leading-zero count within the top SHIFT_STEP bits (window never passes f[0]).
    step_win_zero = 1'b1;
    step_k        = 6'd0;
    for (int i = 0; i < SHIFT_STEP; i++) begin
      if (step_win_zero && step_f_src[6'(52 - i)]) begin
        step_k        = 6'(i);
        step_win_zero = 1'b0;
      end
    end

    step_sh = step_win_zero ? 6'(SHIFT_STEP) : step_k;
    step_f  = step_f_src << step_sh;
    step_e  = step_e_src - {7'd0, step_sh};
    step_lz = step_lz_src + step_sh;
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    e_d     = e_q;
    f_d     = f_q;
    lz_d    = lz_q;
    flags_d = flags_q;

    case (state_q)
      NORM: begin
        f_d  = step_f;
        e_d  = step_e;
        lz_d = step_lz;
        if (!step_win_zero) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    // Classification overrides the above when a new operand is taken; this
    // covers both IDLE and the back-to-back case in DONE.
    if (accept) begin
      s_d     = fp_in[63];
      lz_d    = 6'd0;
      flags_d = 5'd0;
      state_d = DONE;
      if (exp_is_zero && frac_is_zero) begin
        e_d                = 13'd0;
        f_d                = 53'd0;
        flags_d[FLAG_ZERO] = 1'b1;
      end else if (exp_is_max) begin
        // NaN carries the same exponent encoding as infinity.
        e_d = {2'b00, exp_max} - bias;
        f_d = {1'b1, frac};
        if (frac_is_zero) begin
          flags_d[FLAG_INF] = 1'b1;
        end else begin
          flags_d[FLAG_NAN]  = 1'b1;
          flags_d[FLAG_SNAN] = ~frac[51];
        end
      end else if (exp_is_zero) begin
        flags_d[FLAG_DENORM] = 1'b1;
`ifdef FP_UNPACK_FTZ_EN
        e_d                = 13'd0;
        f_d                = 53'd0;
        flags_d[FLAG_ZERO] = 1'b1;
`else
        e_d  = step_e;
        f_d  = step_f;
        lz_d = step_lz;
        if (step_win_zero) state_d = NORM;
`endif
      end else begin
        e_d = {2'b00, exp_fld} - bias;
        f_d = {1'b1, frac};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      e_q     <= 13'd0;
      f_q     <= 53'd0;
      lz_q    <= 6'd0;
      flags_q <= 5'd0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      e_q     <= e_d;
      f_q     <= f_d;
      lz_q    <= lz_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign e         = e_q;
  assign f         = f_q;
  assign lz        = lz_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_unpacker.sv
// tb_fp_unpacker: table vectors, hand sequences and random operands against a reference model.
// Latency: measured per operand from the accept edge to out_valid.
// Backpressure: exercised with out_ready stalls and a back-to-back take/accept.
module tb_fp_unpacker;

  localparam int SS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        db;
  logic [63:0] fp_in;
  logic        out_valid;
  logic        out_ready;
  logic        s;
  logic [12:0] e;
  logic [52:0] f;
  logic [5:0]  lz;
  logic [4:0]  flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_unpacker #(.SHIFT_STEP(SS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .db        (db),
    .fp_in     (fp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .e         (e),
    .f         (f),
    .lz        (lz),
    .flags     (flags)
  );

  typedef struct {
    logic        db;
    logic [63:0] fp;
    logic        xs;
    logic [12:0] xe;
    logic        check_e;
    logic [52:0] xf;
    logic [5:0]  xlz;
    logic [4:0]  xflags;
    int          xlat;
  } vec_t;

  localparam logic [52:0] ONE52 = 53'h10000000000000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Build a table record; in the flush-to-zero build denormal records collapse to signed zero.
  function automatic vec_t mk(input logic d, input logic [63:0] w, input logic xs,
                              input logic [12:0] xe, input logic ce, input logic [52:0] xf,
                              input logic [5:0] xlz, input logic [4:0] xflags, input int xlat);
    vec_t r;
    r.db = d; r.fp = w; r.xs = xs; r.xe = xe; r.check_e = ce; r.xf = xf;
    r.xlz = xlz; r.xflags = xflags; r.xlat = xlat;
`ifdef FP_UNPACK_FTZ_EN
    if (xflags[0]) begin
      r.xe = 13'd0; r.xf = 53'd0; r.xlz = 6'd0; r.xflags = 5'b10001; r.xlat = 1; r.check_e = 1'b1;
    end
`endif
    return r;
  endfunction

  // Reference model: value-level decode straight from the IEEE field rules.
  function automatic vec_t model(input logic d, input logic [63:0] w);
    vec_t        r;
    int          ex, bias, emax, ev, nlz;
    logic [51:0] fr;
    logic [52:0] m;
    r.db = d; r.fp = w; r.xs = w[63]; r.xlz = 6'd0; r.xflags = 5'd0; r.xlat = 1; r.check_e = 1'b1;
    r.xe = 13'd0; r.xf = 53'd0;
    if (d) begin
      ex = int'(w[62:52]); fr = w[51:0]; bias = 1023; emax = 2047;
    end else begin
      ex = int'(w[62:55]); fr = {w[54:32], 29'b0}; bias = 127; emax = 255;
    end
    if (ex == 0 && fr == 52'd0) begin
      r.xflags = 5'b10000;
    end else if (ex == emax) begin
      r.xf = {1'b1, fr};
      r.xe = 13'(emax - bias);
      if (fr == 52'd0) begin
        r.xflags = 5'b00100;
      end else begin
        r.xflags = {1'b0, 1'b1, 1'b0, ~fr[51], 1'b0};
        r.check_e = 1'b0;
      end
    end else if (ex == 0) begin
`ifdef FP_UNPACK_FTZ_EN
      r.xflags = 5'b10001;
`else
      m = {1'b0, fr};
      nlz = 0;
      while (!m[52]) begin
        m = m << 1;
        nlz++;
      end
      ev = 1 - bias - nlz;
      r.xf = m;
      r.xe = 13'(ev);
      r.xlz = 6'(nlz);
      r.xflags = 5'b00001;
      r.xlat = nlz / SS + 1;
`endif
    end else begin
      r.xe = 13'(ex - bias);
      r.xf = {1'b1, fr};
    end
    return r;
  endfunction

  task automatic run_op(input vec_t v, input string name, input int stall);
    int lat;
    @(negedge clk);
    db = v.db; fp_in = v.fp; in_valid = 1'b1; out_ready = 1'b0;
    chk({name, " in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    fp_in = {$urandom(), $urandom()};
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'(v.xlat));
    repeat (stall) @(negedge clk);
    chk({name, " out_valid"}, 64'(out_valid), 64'd1);
    chk({name, " s"}, 64'(s), 64'(v.xs));
    if (v.check_e) chk({name, " e"}, 64'(e), 64'(v.xe));
    chk({name, " f"}, 64'(f), 64'(v.xf));
    chk({name, " lz"}, 64'(lz), 64'(v.xlz));
    chk({name, " flags"}, 64'(flags), 64'(v.xflags));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " drained"}, 64'(out_valid), 64'd0);
  endtask

  vec_t tbl[$];
  vec_t va, vb;
  int   seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; db = 1'b0; fp_in = 64'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst s", 64'(s), 64'd0);
    chk("rst e", 64'(e), 64'd0);
    chk("rst f", 64'(f), 64'd0);
    chk("rst lz", 64'(lz), 64'd0);
    chk("rst flags", 64'(flags), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst in_ready", 64'(in_ready), 64'd1);

    // Directed vectors: db, word, s, e, check_e, f, lz, flags, latency
    tbl.push_back(mk(1, 64'h3FF0000000000000, 0, 13'h0000, 1, ONE52, 0, 5'b00000, 1));
    tbl.push_back(mk(1, 64'h0000000000000001, 0, 13'h1BCE, 1, ONE52, 52, 5'b00001, 7));
    tbl.push_back(mk(0, 64'h80000000_A5A5A5A5, 1, 13'h0000, 1, 53'd0, 0, 5'b10000, 1));
    tbl.push_back(mk(0, 64'h00400000_DEADBEEF, 0, 13'h1F81, 1, ONE52, 1, 5'b00001, 1));
    tbl.push_back(mk(1, 64'h7FF0000000000001, 0, 13'h0400, 0, 53'h10000000000001, 0, 5'b01010, 1));
    tbl.push_back(mk(1, 64'h7FF8000000000000, 0, 13'h0400, 0, 53'h18000000000000, 0, 5'b01000, 1));
    tbl.push_back(mk(1, 64'hFFF0000000000000, 1, 13'h0400, 1, ONE52, 0, 5'b00100, 1));
    tbl.push_back(mk(0, 64'h40490FDB_00000000, 0, 13'h0001, 1, 53'h1921FB60000000, 0, 5'b00000, 1));
    tbl.push_back(mk(0, 64'hFF800000_12345678, 1, 13'h0080, 1, ONE52, 0, 5'b00100, 1));
    tbl.push_back(mk(1, 64'h0008000000000000, 0, 13'h1C01, 1, ONE52, 1, 5'b00001, 1));
    tbl.push_back(mk(1, 64'h0000000000000100, 0, 13'h1BD6, 1, ONE52, 44, 5'b00001, 6));
    tbl.push_back(mk(1, 64'h8000100000000000, 1, 13'h1BFA, 1, ONE52, 8, 5'b00001, 2));
    tbl.push_back(mk(0, 64'h00000001_FFFFFFFF, 0, 13'h1F6B, 1, ONE52, 23, 5'b00001, 3));
    foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i), i % 3);

    // Backpressure hold, then take + accept on the same edge
    va = mk(1, 64'h3FF0000000000000, 0, 13'h0000, 1, ONE52, 0, 5'b00000, 1);
    vb = mk(0, 64'hC0000000_12345678, 1, 13'h0001, 1, ONE52, 0, 5'b00000, 1);
    @(negedge clk);
    db = va.db; fp_in = va.fp; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("bp out_valid", 64'(out_valid), 64'd1);
      chk("bp in_ready", 64'(in_ready), 64'd0);
      chk("bp e", 64'(e), 64'(va.xe));
      chk("bp f", 64'(f), 64'(va.xf));
      chk("bp flags", 64'(flags), 64'(va.xflags));
      @(negedge clk);
    end
    db = vb.db; fp_in = vb.fp; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b out_valid", 64'(out_valid), 64'd1);
    chk("b2b s", 64'(s), 64'(vb.xs));
    chk("b2b e", 64'(e), 64'(vb.xe));
    chk("b2b f", 64'(f), 64'(vb.xf));
    chk("b2b flags", 64'(flags), 64'(vb.xflags));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b drained", 64'(out_valid), 64'd0);

    // Reset while the smallest double denormal is normalizing
    @(negedge clk);
    db = 1'b1; fp_in = 64'h0000000000000001; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort flags", 64'(flags), 64'd0);
    chk("abort in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("abort discarded", 64'(seen), 64'd0);
    out_ready = 1'b0;

    // Random operands against the reference model
    for (int n = 0; n < 150; n++) begin
      logic        d, sg;
      logic [51:0] fr;
      logic [63:0] w;
      int          cat, ex, emax;
      cat  = int'($urandom_range(0, 5));
      d    = 1'($urandom_range(0, 1));
      sg   = 1'($urandom_range(0, 1));
      emax = d ? 2047 : 255;
      fr   = 52'({$urandom(), $urandom()});
      case (cat)
        0: begin ex = 0; fr = 52'd0; end
        1, 2: ex = int'($urandom_range(1, emax - 1));
        3: begin ex = emax; fr = 52'd0; end
        4: ex = emax;
        default: begin ex = 0; fr = fr >> $urandom_range(0, 51); end
      endcase
      if (cat >= 4) begin
        if (d) begin
          if (fr == 52'd0) fr[0] = 1'b1;
        end else if (fr[51:29] == 23'd0) begin
          fr[29] = 1'b1;
        end
      end
      if (d) w = {sg, 11'(ex), fr};
      else   w = {sg, 8'(ex), fr[51:29], $urandom()};
      run_op(model(d, w), $sformatf("rnd%0d", n), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_unpacker.md
Name: fp_unpacker

Overview:
- Operand-side unpacker: converts an IEEE single or double word into the FPU's internal unpacked form (sign, 13-bit two's-complement exponent, 53-bit significand with explicit leading bit, special-case flags).
- Denormals are normalized iteratively, up to SHIFT_STEP bit positions per cycle.
- Sits between the operand register file and the adder/multiplier datapath.
- Inverse of the rounder/packer at the result end; its flags match the rounder's special-case flag vector.

Parameters:
- SHIFT_STEP, 8: maximum left-shift positions per normalization cycle; legal range 1..53.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand present.
- in_ready  out  1  unpacker can accept an operand.
- db  in  1  1 = double, 0 = single.
- fp_in  in  64  operand. Double uses [63:0]; single uses [63:32], and [31:0] is ignored.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- s  out  1  sign.
- e  out  13  unbiased exponent, two's complement.
- f  out  53  significand; f[52] is the leading bit.
- lz  out  6  normalization shift applied to a denormal.
- flags  out  5  {ZERO, NAN, INF, SNAN, DENORM}.

Behaviour:
- Reset: state IDLE; out_valid, s, e, f, lz, flags all 0; in_ready 1 in the cycle after reset. Reset in any state aborts the operation and discards it.
- Handshakes: input transfer on in_valid & in_ready; output transfer on out_valid & out_ready. in_ready = (state==IDLE) | (state==DONE & out_ready).
- Back-to-back: a new operand may be accepted on the same edge the previous result is taken.
- Output stability: while out_valid=1 and out_ready=0, all outputs hold stable.
- Field extraction:
  - Double: exp = fp_in[62:52], frac = fp_in[51:0], bias 1023, emax 2047.
  - Single: exp = fp_in[62:55], frac = {fp_in[54:32], 29'b0}, bias 127, emax 255.
  - s = fp_in[63].
- Classification at accept; the accept edge loads the next state:
  - ZERO (exp=0, frac=0): e=0, f=0 -> DONE.
  - Normal (0<exp<emax): e = exp - bias, f = {1, frac} -> DONE.
  - INF (exp=emax, frac=0): e = emax - bias, f = {1, 52'b0} -> DONE.
  - NAN (exp=emax, frac!=0): f = {1, frac}. SNAN=1 when the frac MSB (double bit 51, single bit 54) is 0. -> DONE.
  - Denormal (exp=0, frac!=0): DENORM=1, working f = {0, frac}, e = 1 - bias, lz = 0 -> NORM.
- NORM (one edge per cycle):
  - If f[52 -: SHIFT_STEP] is all zero: f <<= SHIFT_STEP, e -= SHIFT_STEP, lz += SHIFT_STEP, stay in NORM.
  - Otherwise: with k = leading zeros in that window, f <<= k, e -= k, lz += k -> DONE.
  - When SHIFT_STEP exceeds the remaining bits, the window is truncated at f[0].
- Latency from the accept edge to out_valid:
  - Non-denormals: 1 edge.
  - Denormals: floor(lz_final / SHIFT_STEP) + 1 edges.
- DONE: out_valid=1. On out_ready -> IDLE, or straight to the next classification if in_valid=1 the same cycle.
- Exponent range: minimum double e is -1074, minimum single e is -149; both fit 13 bits and need no saturation.

Optional Feature:
- Macro FP_UNPACK_FTZ_EN.
- When defined: a denormal is flushed to zero at accept. s is kept; e=0, f=0, lz=0; ZERO=1 and DENORM=1; goes directly to DONE with latency 1. NORM is never entered.
- When undefined: full iterative normalization as specified in Behaviour.

Test Plan:
- db=1, fp_in=0x3FF0000000000000 -> after 1 edge: s=0, e=0, f=0x10000000000000, flags=0, lz=0.
- db=1, fp_in=0x0000000000000001, SHIFT_STEP=8 -> out_valid after 7 edges: e=-1074 (13'h1BCE), f=0x10000000000000, lz=52, DENORM=1. With FP_UNPACK_FTZ_EN: after 1 edge, f=0, ZERO=1, DENORM=1.
- db=0, fp_in[63:32]=0x80000000 -> s=1, ZERO=1, e=0, f=0. Then db=0, fp_in[63:32]=0x00400000 -> lz=1, e=-127, f[52]=1, latency 1 edge.
- Specials:
  - 0x7FF0000000000001 -> NAN=1, SNAN=1.
  - 0x7FF8000000000000 -> NAN=1, SNAN=0.
  - 0xFFF0000000000000 -> INF=1, s=1, e=1024.
- Backpressure: hold out_ready=0 for 5 cycles -> outputs and out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 -> old result taken and new operand accepted on the same edge, with no bubble.
- Assert rst during NORM of 0x0000000000000001 -> next cycle: out_valid=0, flags=0, in_ready=1, and the operand is never output.
